vsfx_wb: RTL

- Writeback stage directly downstream of the vector simple fixed-point unit.
- Consumes its result (vrt, vrt_en, sat, cr6) and queues results in an in-order FIFO.
- Drains the FIFO to the shared vector register file write port under an ack handshake.
- Maintains the sticky VSCR[SAT] bit and the CR field 6 value for record-form instructions.

---
 rtl/vsfx_wb.sv | 107 ++++++++++
 1 files changed

// File: rtl/vsfx_wb.sv
// Writeback stage for the vector simple fixed-point unit: in-order result FIFO
// feeding the VR file write port, plus sticky VSCR[SAT] and CR6 tracking.
// Optional define VSFX_WB_BYPASS_EN adds a youngest-match forwarding search of queued results.
module vsfx_wb #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [127:0] in_vrt,
    input  logic         in_sat,
    input  logic [3:0]   in_cr6,
    input  logic [4:0]   in_tgt,
    input  logic         in_rc,
    output logic         in_ready,
    output logic         rf_we,
    output logic [4:0]   rf_addr,
    output logic [127:0] rf_data,
    input  logic         rf_ack,
    output logic         vscr_sat,
    input  logic         vscr_clr,
    output logic [3:0]   cr6,
    output logic         cr6_upd
`ifdef VSFX_WB_BYPASS_EN
    ,
    input  logic [4:0]   byp_addr,
    output logic         byp_hit,
    output logic [127:0] byp_data
`endif
);

    typedef struct packed {
        logic [4:0]   tgt;
        logic [127:0] vrt;
    } wb_entry_t;

    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    wb_entry_t       mem [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [AW:0]     count;
    logic            push, pop;

    // in_ready looks only at registered count, so a full FIFO never takes a
    // push even when the head is popped in the same cycle.
    assign in_ready = (count != FULL);
    assign rf_we    = (count != '0);
    assign push     = in_valid && in_ready;
    assign pop      = rf_we && rf_ack;
    assign rf_addr  = rf_we ? mem[rd_ptr].tgt : 5'd0;
    assign rf_data  = rf_we ? mem[rd_ptr].vrt : 128'd0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Payload storage needs no reset; count gates every read of it.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= '{tgt: in_tgt, vrt: in_vrt};
    end

    // Status is committed at acceptance, ahead of the VR write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vscr_sat <= 1'b0;
            cr6      <= 4'd0;
            cr6_upd  <= 1'b0;
        end else begin
            if (push && in_sat)  vscr_sat <= 1'b1;
            else if (vscr_clr)   vscr_sat <= 1'b0;
            cr6_upd <= push && in_rc;
            if (push && in_rc)   cr6 <= in_cr6;
        end
    end

`ifdef VSFX_WB_BYPASS_EN
    logic [AW-1:0] byp_idx;

    // Walk oldest to youngest so the last match wins.
    always_comb begin
        byp_hit  = 1'b0;
        byp_data = '0;
        byp_idx  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            byp_idx = rd_ptr + AW'(i);
            if (((AW+1)'(i) < count) && (mem[byp_idx].tgt == byp_addr)) begin
                byp_hit  = 1'b1;
                byp_data = mem[byp_idx].vrt;
            end
        end
    end
`endif

endmodule
